// File: rtl/seq_pkg.sv
// Shared types and opcode definitions for the instruction sequencer.
// The opcode set lives here so the decoder and any future tooling agree on it.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALTED  = 3'd4
    } state_t;

    // Opcodes are held zero-extended to 32 bits so any OPC_W up to 32 compares cleanly.
    localparam logic [31:0] OP_ADD  = 32'h1;
    localparam logic [31:0] OP_SUB  = 32'h2;
    localparam logic [31:0] OP_MUL  = 32'h3;
    localparam logic [31:0] OP_GCD  = 32'hB;
    localparam logic [31:0] OP_HALT = 32'hF;

    function automatic logic is_valid_op(input logic [31:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_GCD);
    endfunction

endpackage

// File: rtl/seq_op_decoder.sv
// Combinational opcode classifier: flags datapath operations and the HALT opcode.
// Anything that is neither is treated as an undefined opcode by the sequencer.
module seq_op_decoder
    import seq_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] opcode_i,
    output logic             valid_o,
    output logic             halt_o
);

    logic [31:0] opcode_ext;

    assign opcode_ext = 32'(opcode_i);
    assign valid_o    = is_valid_op(opcode_ext);
    assign halt_o     = (opcode_ext == OP_HALT);

endmodule

// File: rtl/instr_sequencer.sv
// Instruction fetch/decode/dispatch sequencer with run/step modes, sticky HALTED and retire counter.
// Optional EXECUTE watchdog enabled by defining SEQ_TIMEOUT_EN.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int OPC_W     = 4,
    parameter int ADDR      = 5,
    parameter int INSTR_LEN = OPC_W + 2 * DATA_W,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    input  logic                 step_mode,
    input  logic [INSTR_LEN-1:0] instruction,
    input  logic                 done,
    output logic                 enable,
    output logic [ADDR-1:0]      pc,
    output logic [OPC_W-1:0]     opcode,
    output logic [DATA_W-1:0]    a,
    output logic [DATA_W-1:0]    b,
    output logic                 invalid_opcode,
    output logic                 busy,
    output logic                 halted,
    output logic [CNT_W-1:0]     retired,
    output logic                 timeout
);

    state_t             state_q, state_d;
    logic [ADDR-1:0]    pc_q, pc_d;
    logic [OPC_W-1:0]   opcode_q, opcode_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               dec_valid;
    logic               dec_halt;

`ifdef SEQ_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT);
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               timeout_q, timeout_d;
`endif

    seq_op_decoder #(
        .OPC_W (OPC_W)
    ) u_dec (
        .opcode_i (opcode_q),
        .valid_o  (dec_valid),
        .halt_o   (dec_halt)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        a_d       = a_q;
        b_d       = b_q;
        retired_d = retired_q;
`ifdef SEQ_TIMEOUT_EN
        tmr_d     = '0;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (go) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                opcode_d = instruction[INSTR_LEN-1 -: OPC_W];
                a_d      = instruction[2*DATA_W-1 -: DATA_W];
                b_d      = instruction[DATA_W-1:0];
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec_halt) begin
                    state_d = ST_HALTED;
                end else if (dec_valid) begin
                    state_d = ST_EXECUTE;
                end else begin
                    // Undefined opcode is skipped like a completed instruction, minus the retire.
                    pc_d    = pc_q + 1'b1;
                    state_d = step_mode ? ST_IDLE : ST_FETCH;
                end
            end
            ST_EXECUTE: begin
                if (done) begin
                    pc_d      = pc_q + 1'b1;
                    retired_d = retired_q + 1'b1;
                    state_d   = step_mode ? ST_IDLE : ST_FETCH;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    pc_d      = pc_q + 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
`endif
            end
            ST_HALTED: begin
                if (go) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            opcode_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            retired_q <= '0;
`ifdef SEQ_TIMEOUT_EN
            tmr_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            a_q       <= a_d;
            b_q       <= b_d;
            retired_q <= retired_d;
`ifdef SEQ_TIMEOUT_EN
            tmr_q     <= tmr_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign enable         = (state_q == ST_EXECUTE);
    assign invalid_opcode = (state_q == ST_DECODE) && !dec_valid && !dec_halt;
    assign busy           = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXECUTE);
    assign halted         = (state_q == ST_HALTED);
    assign pc             = pc_q;
    assign opcode         = opcode_q;
    assign a              = a_q;
    assign b              = b_q;
    assign retired        = retired_q;
`ifdef SEQ_TIMEOUT_EN
    assign timeout        = timeout_q;
`else
    assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a program-level model predicts retire/invalid/halt/timeout
// events per go request; a negedge monitor pops and compares them as the DUT presents them.
module tb_instr_sequencer;

    localparam int DATA_W  = 8;
    localparam int OPC_W   = 4;
    localparam int ADDR    = 5;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 8;
    localparam int IL      = OPC_W + 2 * DATA_W;
    localparam int DEPTH   = 1 << ADDR;

    localparam int EV_RETIRE  = 0;
    localparam int EV_INVALID = 1;
    localparam int EV_HALT    = 2;
    localparam int EV_TIMEOUT = 3;

    logic              clk = 1'b0;
    logic              reset, go, step_mode, done;
    logic [IL-1:0]     instruction;
    logic              enable, invalid_opcode, busy, halted, timeout;
    logic [ADDR-1:0]   pc;
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] a, b;
    logic [CNT_W-1:0]  retired;

    logic [IL-1:0] mem [DEPTH];
    assign instruction = mem[pc];

    always #5 clk = ~clk;

    instr_sequencer #(
        .DATA_W (DATA_W), .OPC_W (OPC_W), .ADDR (ADDR),
        .INSTR_LEN (IL), .CNT_W (CNT_W), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk), .reset (reset), .go (go), .step_mode (step_mode),
        .instruction (instruction), .done (done), .enable (enable), .pc (pc),
        .opcode (opcode), .a (a), .b (b), .invalid_opcode (invalid_opcode),
        .busy (busy), .halted (halted), .retired (retired), .timeout (timeout)
    );

    typedef struct {
        int kind;
        int pc;
        int op;
        int av;
        int bv;
        int ret;
    } ev_t;

    ev_t sb_q[$];
    int  errors = 0;
    int  checks = 0;

    // Architectural model: program counter, retire count, halted flag.
    int m_pc = 0;
    int m_ret = 0;
    bit m_halted = 1'b0;

    int valid_ops[4] = '{1, 2, 3, 11};
    int bad_ops[11]  = '{0, 4, 5, 6, 7, 8, 9, 10, 12, 13, 14};

    // Datapath stand-in controls.
    int lat_min = 0, lat_max = 3;
    bit hold_done = 1'b0, noise_en = 1'b1;
    bit en_seen = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [IL-1:0] mk(input int op, input int av, input int bv);
        return {OPC_W'(op), DATA_W'(av), DATA_W'(bv)};
    endfunction

    // One go request: walk the program from the model pc following the instruction rules.
    function automatic void model_go(input bit step, input bit hold);
        ev_t e;
        logic [IL-1:0] w;
        int op;
        if (m_halted) begin
            m_pc = 0;
            m_halted = 1'b0;
        end
        for (int guard = 0; guard < 4 * DEPTH; guard++) begin
            w     = mem[m_pc];
            op    = int'(w[IL-1 -: OPC_W]);
            e.pc  = m_pc;
            e.op  = op;
            e.av  = int'(w[2*DATA_W-1 -: DATA_W]);
            e.bv  = int'(w[DATA_W-1:0]);
            e.ret = m_ret;
            if (op == 15) begin
                e.kind = EV_HALT;
                sb_q.push_back(e);
                m_halted = 1'b1;
                return;
            end else if (op == 1 || op == 2 || op == 3 || op == 11) begin
                if (hold) begin
`ifdef SEQ_TIMEOUT_EN
                    m_pc   = (m_pc + 1) % DEPTH;
                    e.kind = EV_TIMEOUT;
                    e.pc   = m_pc;
                    sb_q.push_back(e);
`endif
                    return;
                end
                e.kind = EV_RETIRE;
                sb_q.push_back(e);
                m_ret = (m_ret + 1) % (1 << CNT_W);
                m_pc  = (m_pc + 1) % DEPTH;
            end else begin
                e.kind = EV_INVALID;
                sb_q.push_back(e);
                m_pc = (m_pc + 1) % DEPTH;
            end
            if (step) return;
        end
    endfunction

    // Datapath: answers done after a random latency in EXECUTE; random noise on done elsewhere.
    initial begin
        int exec_cnt;
        int lat;
        exec_cnt = 0;
        lat = 0;
        done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (enable) begin
                done = !hold_done && (exec_cnt == lat);
                exec_cnt++;
            end else begin
                exec_cnt = 0;
                lat  = $urandom_range(lat_max, lat_min);
                done = noise_en && ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor
    int en_run = 0, last_run = 0;
    logic halted_prev = 1'b0;

    task automatic observe(input int k);
        ev_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d at pc %0d, expected no event", k, pc);
            return;
        end
        e = sb_q.pop_front();
        check("event_kind", k, e.kind);
        check("event_pc", pc, e.pc);
        check("event_retired", retired, e.ret);
        if (k == EV_RETIRE) begin
            check("retire_opcode", opcode, e.op);
            check("retire_a", a, e.av);
            check("retire_b", b, e.bv);
        end
        if (k == EV_INVALID) check("invalid_enable", enable, 0);
        if (k == EV_TIMEOUT) check("timeout_enable_cycles", last_run, TIMEOUT);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            en_run = 0;
            halted_prev = 1'b0;
        end else begin
            if (enable) begin
                en_run++;
                en_seen = 1'b1;
            end else begin
                if (en_run != 0) last_run = en_run;
                en_run = 0;
            end
            if (enable && done)        observe(EV_RETIRE);
            if (invalid_opcode)        observe(EV_INVALID);
            if (halted && !halted_prev) observe(EV_HALT);
            if (timeout)               observe(EV_TIMEOUT);
            halted_prev = halted;
        end
    end

    task automatic pulse_go();
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || sb_q.size() != 0) && n < 2000);
        if (n >= 2000) check("wait_idle_bound", n, 0);
    endtask

    task automatic issue(input bit step, input bit extra_go);
        step_mode = step;
        model_go(step, 1'b0);
        pulse_go();
        if (extra_go) begin
            go = 1'b1;
            @(posedge clk);
            #1 go = 1'b0;
        end
        wait_idle();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        m_pc = 0;
        m_ret = 0;
        m_halted = 1'b0;
        sb_q.delete();
        hold_done = 1'b0;
    endtask

    task automatic random_program();
        for (int i = 0; i < DEPTH; i++) begin
            int v;
            v = $urandom_range(0, 9);
            if (v < 6)      mem[i] = mk(valid_ops[$urandom_range(0, 3)], $urandom, $urandom);
            else if (v < 9) mem[i] = mk(bad_ops[$urandom_range(0, 10)], $urandom, $urandom);
            else            mem[i] = mk(15, $urandom, $urandom);
        end
        mem[$urandom_range(0, DEPTH - 1)] = mk(15, 0, 0);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        go = 1'b0;
        step_mode = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = mk(1, i, i + 1);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 0);
        check("rst_enable", enable, 0);
        check("rst_retired", retired, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_invalid", invalid_opcode, 0);
        check("rst_timeout", timeout, 0);
        check("rst_opcode", opcode, 0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Reset mid-EXECUTE at pc=3
        for (int i = 0; i < 3; i++) issue(1'b1, 1'b0);
        check("pre_reset_pc", pc, 3);
        check("pre_reset_retired", retired, 3);
        hold_done = 1'b1;
        step_mode = 1'b1;
        pulse_go();
        repeat (3) @(negedge clk);
        check("midexec_enable", enable, 1);
        check("midexec_pc", pc, 3);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_pc", pc, 0);
        check("abort_enable", enable, 0);
        check("abort_retired", retired, 0);
        check("abort_busy", busy, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        m_pc = 0; m_ret = 0; m_halted = 1'b0; sb_q.delete(); hold_done = 1'b0;

        // Run mode ADD,SUB,MUL,HALT with single-cycle datapath: 12 cycles go->halted
        mem[0] = mk(1, 10, 20); mem[1] = mk(2, 30, 5); mem[2] = mk(3, 7, 9); mem[3] = mk(15, 0, 0);
        lat_min = 0; lat_max = 0;
        step_mode = 1'b0;
        model_go(1'b0, 1'b0);
        @(negedge clk);
        go = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            #1 go = 1'b0;
        end while (!halted && cyc < 100);
        check("go_to_halted_cycles", cyc, 12);
        wait_idle();
        check("run_retired", retired, 3);
        check("run_pc", pc, 3);
        check("run_halted", halted, 1);

        // Step mode, with a go while busy each time
        lat_max = 3;
        for (int i = 0; i < 3; i++) issue(1'b1, 1'b1);
        check("step_pc", pc, 3);
        check("step_retired", retired, 6);
        check("step_halted", halted, 0);
        issue(1'b1, 1'b1);
        check("step_halt", halted, 1);

        // Undefined opcode at pc=0
        do_reset();
        mem[0] = mk(7, 1, 2); mem[1] = mk(15, 0, 0);
        en_seen = 1'b0;
        issue(1'b1, 1'b0);
        check("invalid_pc", pc, 1);
        check("invalid_retired", retired, 0);
        check("invalid_no_enable", en_seen, 0);

        // pc wrap 31 -> 0
        do_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = mk(valid_ops[$urandom_range(0, 3)], $urandom, $urandom);
        for (int i = 0; i < DEPTH - 1; i++) issue(1'b1, 1'($urandom_range(0, 1)));
        check("wrap_pre_pc", pc, DEPTH - 1);
        mem[1] = mk(15, 0, 0);
        issue(1'b0, 1'b0);
        check("wrap_pc", pc, 1);
        check("wrap_retired", retired, DEPTH + 1);

        // done on the last allowed EXECUTE cycle completes normally
        do_reset();
        mem[0] = mk(11, 48, 18); mem[1] = mk(2, 3, 4);
        lat_min = TIMEOUT - 1; lat_max = TIMEOUT - 1;
        issue(1'b1, 1'b0);
        check("late_done_retired", retired, 1);
        check("late_done_pc", pc, 1);

        // Datapath never answers
        lat_min = 0; lat_max = 3;
        hold_done = 1'b1;
        step_mode = 1'b0;
        model_go(1'b0, 1'b1);
        pulse_go();
`ifdef SEQ_TIMEOUT_EN
        wait_idle();
        check("hold_pc", pc, 2);
        check("hold_enable", enable, 0);
        check("hold_retired", retired, 1);
        hold_done = 1'b0;
`else
        repeat (TIMEOUT + 12) @(negedge clk);
        check("hold_enable", enable, 1);
        check("hold_pc", pc, 1);
        check("hold_timeout", timeout, 0);
        do_reset();
`endif

        // Randomised programs and modes
        for (int r = 0; r < 40; r++) begin
            if (r % 8 == 0) random_program();
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check("rand_pc", pc, m_pc);
            check("rand_retired", retired, m_ret);
            check("rand_halted", halted, m_halted);
        end

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
